// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and constants for the responder and the future APB bridge.
// Transfer, size and response encodings plus the responder FSM state type.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [2:0] {
      HSIZE_BYTE = 3'd0,
      HSIZE_HALF = 3'd1,
      HSIZE_WORD = 3'd2
   } hsize_t;

   typedef enum logic {
      HRESP_OKAY  = 1'b0,
      HRESP_ERROR = 1'b1
   } hresp_t;

   typedef enum logic [2:0] {
      StIdle,
      StWait,
      StData,
      StErr1,
      StErr2
   } ahb_slv_state_t;

   // Sizes above a word are flagged separately, so only half and word can misalign here.
   function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr);
      logic mis;
      mis = 1'b0;
      case (size)
         HSIZE_HALF: mis = addr[0];
         HSIZE_WORD: mis = (addr != 2'b00);
         default:    mis = 1'b0;
      endcase
      return mis;
   endfunction

   function automatic logic is_active(input logic [1:0] trans);
      return trans[1];
   endfunction

endpackage

// File: rtl/ahb_byte_strobe.sv
// Little-endian byte-lane strobe from a transfer size and the low address bits.
// Unsupported sizes yield no strobes.
module ahb_byte_strobe
   import ahb_pkg::*;
(
   input  logic [2:0] hsize,
   input  logic [1:0] addr,
   output logic [3:0] strobe
);

   always_comb begin
      strobe = 4'b0000;
      case (hsize)
         HSIZE_BYTE: strobe = 4'b0001 << addr;
         HSIZE_HALF: strobe = addr[1] ? 4'b1100 : 4'b0011;
         HSIZE_WORD: strobe = 4'b1111;
         default:    strobe = 4'b0000;
      endcase
   end

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite responder backed by a register-file memory, with fixed wait-state insertion
// and the two-cycle ERROR response for out-of-range, oversize or misaligned transfers.
module ahb_mem_slave
   import ahb_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned MEM_BYTES   = 1024,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic              hclk,
   input  logic              hreset,
   input  logic              hsel,
   input  logic [ADDR_W-1:0] haddr,
   input  logic [1:0]        htrans,
   input  logic              hwrite,
   input  logic [2:0]        hsize,
   input  logic [2:0]        hburst,
   input  logic [DATA_W-1:0] hwdata,
   input  logic              hready,
   output logic [DATA_W-1:0] hrdata,
   output logic              hreadyout,
   output logic              hresp
);

   localparam int unsigned IDX_W  = $clog2(MEM_BYTES);
   localparam int unsigned WORDS  = MEM_BYTES / 4;
   localparam int unsigned WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   ahb_slv_state_t     state_q, state_d;
   logic [IDX_W-1:0]   addr_q, addr_d;
   logic               write_q, write_d;
   logic [2:0]         size_q, size_d;
   logic [3:0]         cnt_q, cnt_d;

   logic               capture;
   logic               xfer_err;
   logic [3:0]         strobe;
   logic [WORD_W-1:0]  word_idx;
   logic [DATA_W-1:0]  mem [WORDS];

   logic               unused_inputs;
   assign unused_inputs = ^{hburst, htrans[0]};

   assign capture  = hsel & hready & is_active(htrans);
   assign xfer_err = (haddr >= ADDR_W'(MEM_BYTES))
                   | (hsize > 3'd2)
                   | is_misaligned(hsize, haddr[1:0]);

   ahb_byte_strobe u_strobe (
      .hsize  (size_q),
      .addr   (addr_q[1:0]),
      .strobe (strobe)
   );

   assign word_idx = WORD_W'(addr_q >> 2);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      write_d = write_q;
      size_d  = size_q;
      cnt_d   = cnt_q;
      case (state_q)
         StWait: begin
            if (cnt_q == 4'd0) begin
               state_d = StData;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StErr1: state_d = StErr2;
         default: begin
            // Idle, the completing data beat and the second error cycle all accept a new
            // address phase, which is what gives back-to-back pipelining.
            state_d = StIdle;
            if (capture) begin
               addr_d  = haddr[IDX_W-1:0];
               write_d = hwrite;
               size_d  = hsize;
               if (xfer_err) begin
                  state_d = StErr1;
               end else if (WAIT_CYCLES > 0) begin
                  state_d = StWait;
                  cnt_d   = CNT_INIT;
               end else begin
                  state_d = StData;
               end
            end
         end
      endcase
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state_q <= StIdle;
         addr_q  <= '0;
         write_q <= 1'b0;
         size_q  <= 3'd0;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         size_q  <= size_d;
         cnt_q   <= cnt_d;
      end
   end

   // Memory is deliberately outside the reset domain; reset only cancels a pending commit.
   always_ff @(posedge hclk) begin
      if (state_q == StData && write_q) begin
         for (int b = 0; b < 4; b++) begin
            if (strobe[b]) begin
               mem[word_idx][8*b +: 8] <= hwdata[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      hreadyout = 1'b1;
      hresp     = HRESP_OKAY;
      hrdata    = '0;
      case (state_q)
         StWait: hreadyout = 1'b0;
         StData: begin
            if (!write_q) begin
               hrdata = mem[word_idx];
            end
         end
         StErr1: begin
            hreadyout = 1'b0;
            hresp     = HRESP_ERROR;
         end
         StErr2: hresp = HRESP_ERROR;
         default: hreadyout = 1'b1;
      endcase
   end

endmodule
